pong_game_engine: RTL and testbench



---
 rtl/pong_game_engine_if.sv | 30 +++
 rtl/pong_game_engine.sv | 178 +++++++++++++++++
 tb/tb_pong_game_engine.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/pong_game_engine_if.sv
// Engine-side bundle: player controls and game-step strobe in, registered game state out.
interface pong_game_engine_if #(
  parameter int POS_W   = 10,
  parameter int SCORE_W = 4
);
  logic               tick;
  logic               start;
  logic               p1Up;
  logic               p1Down;
  logic               p2Up;
  logic               p2Down;
  logic [POS_W-1:0]   ballX;
  logic [POS_W-1:0]   ballY;
  logic [POS_W-1:0]   paddle1Y;
  logic [POS_W-1:0]   paddle2Y;
  logic [SCORE_W-1:0] score1;
  logic [SCORE_W-1:0] score2;
  logic [1:0]         gameState;
  logic [1:0]         winner;
  logic               pointPulse;

  modport master (
    output tick, start, p1Up, p1Down, p2Up, p2Down,
    input  ballX, ballY, paddle1Y, paddle2Y, score1, score2, gameState, winner, pointPulse
  );
  modport slave (
    input  tick, start, p1Up, p1Down, p2Up, p2Down,
    output ballX, ballY, paddle1Y, paddle2Y, score1, score2, gameState, winner, pointPulse
  );
endinterface

// File: rtl/pong_game_engine.sv
// Two-player Pong core: ball/paddle motion, collisions, scoring and serve/play/over FSM,
// stepped by a one-cycle tick strobe on the system clock.
module pong_game_engine #(
  parameter int H_MIN        = 140,
  parameter int H_MAX        = 790,
  parameter int V_MIN        = 30,
  parameter int V_MAX        = 520,
  parameter int POS_W        = 10,
  parameter int P1_X         = 200,
  parameter int P2_X         = 710,
  parameter int PADDLE_HALF  = 20,
  parameter int PADDLE_STEP  = 2,
  parameter int BALL_VX      = 2,
  parameter int BALL_START_X = 320,
  parameter int BALL_START_Y = 240,
  parameter int SCORE_W      = 4,
  parameter int WIN_SCORE    = 5,
  parameter int SERVE_DELAY  = 60
) (
  input logic               clk,
  input logic               reset,
  pong_game_engine_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SERVE = 2'd1, S_PLAY = 2'd2, S_OVER = 2'd3} state_t;
  typedef logic signed [POS_W+2:0] sp_t;

  localparam int CNT_W = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;
  localparam int PMIN  = V_MIN + PADDLE_HALF;
  localparam int PMAX  = V_MAX - PADDLE_HALF;
  localparam int PMID  = (V_MIN + V_MAX) / 2;

  state_t             r_state, w_state;
  logic [POS_W-1:0]   r_bx, r_by, r_p1, r_p2, w_bx, w_by, w_p1, w_p2;
  logic [SCORE_W-1:0] r_s1, r_s2, w_s1, w_s2;
  logic [1:0]         r_win, w_win;
  logic [CNT_W-1:0]   r_cnt, w_cnt;
  logic               r_pp, w_pp, r_dxr, w_dxr, r_dyd, w_dyd, r_dy2, w_dy2;

  function automatic logic [POS_W-1:0] f_paddle(input logic [POS_W-1:0] y, input logic up, input logic dn);
    sp_t t;
    t = $signed({3'b000, y});
    if (up && !dn)      t = t - sp_t'(PADDLE_STEP);
    else if (dn && !up) t = t + sp_t'(PADDLE_STEP);
    if (t < sp_t'(PMIN))      t = sp_t'(PMIN);
    else if (t > sp_t'(PMAX)) t = sp_t'(PMAX);
    return t[POS_W-1:0];
  endfunction

  // Collision terms use the paddle positions from before this tick's paddle move.
  sp_t  w_sbx, w_sby, w_nx, w_ny, w_d1, w_d2, w_a1, w_a2;
  logic w_hit1, w_hit2, w_pt1, w_pt2;
  logic [POS_W-1:0] w_p1n, w_p2n;

  assign w_sbx  = $signed({3'b000, r_bx});
  assign w_sby  = $signed({3'b000, r_by});
  assign w_nx   = r_dxr ? w_sbx + sp_t'(BALL_VX) : w_sbx - sp_t'(BALL_VX);
  assign w_ny   = r_dyd ? w_sby + (r_dy2 ? sp_t'(2) : sp_t'(1)) : w_sby - (r_dy2 ? sp_t'(2) : sp_t'(1));
  assign w_d1   = w_sby - $signed({3'b000, r_p1});
  assign w_d2   = w_sby - $signed({3'b000, r_p2});
  assign w_a1   = (w_d1 < 0) ? -w_d1 : w_d1;
  assign w_a2   = (w_d2 < 0) ? -w_d2 : w_d2;
  assign w_hit1 = !r_dxr && (w_sbx > sp_t'(P1_X)) && (w_nx <= sp_t'(P1_X)) && (w_a1 <= sp_t'(PADDLE_HALF));
  assign w_hit2 = r_dxr && (w_sbx < sp_t'(P2_X)) && (w_nx >= sp_t'(P2_X)) && (w_a2 <= sp_t'(PADDLE_HALF));
  assign w_pt2  = !w_hit1 && !w_hit2 && (w_nx <= sp_t'(H_MIN));
  assign w_pt1  = !w_hit1 && !w_hit2 && !w_pt2 && (w_nx >= sp_t'(H_MAX));
  assign w_p1n  = f_paddle(r_p1, bus.p1Up, bus.p1Down);
  assign w_p2n  = f_paddle(r_p2, bus.p2Up, bus.p2Down);

  always_comb begin
    w_state = r_state; w_bx = r_bx; w_by = r_by; w_p1 = r_p1; w_p2 = r_p2;
    w_s1 = r_s1; w_s2 = r_s2; w_win = r_win; w_cnt = r_cnt; w_pp = 1'b0;
    w_dxr = r_dxr; w_dyd = r_dyd; w_dy2 = r_dy2;
    unique case (r_state)
      S_IDLE: if (bus.start) begin
        w_state = S_SERVE;
        w_cnt   = '0;
      end
      S_SERVE: if (bus.tick) begin
        w_p1 = w_p1n;
        w_p2 = w_p2n;
        if (r_cnt == CNT_W'(SERVE_DELAY - 1)) w_state = S_PLAY;
        else                                  w_cnt   = r_cnt + CNT_W'(1);
      end
      S_PLAY: if (bus.tick) begin
        w_p1 = w_p1n;
        w_p2 = w_p2n;
        if (w_pt1 || w_pt2) begin
          w_pp  = 1'b1;
          w_bx  = POS_W'(BALL_START_X);
          w_by  = POS_W'(BALL_START_Y);
          w_dy2 = 1'b0;
          w_dxr = w_pt1;  // serve toward whoever conceded
          w_cnt = '0;
          w_state = S_SERVE;
          if (w_pt1) begin
            w_s1 = r_s1 + SCORE_W'(1);
            if (w_s1 == SCORE_W'(WIN_SCORE)) begin w_state = S_OVER; w_win = 2'd1; end
          end else begin
            w_s2 = r_s2 + SCORE_W'(1);
            if (w_s2 == SCORE_W'(WIN_SCORE)) begin w_state = S_OVER; w_win = 2'd2; end
          end
        end else begin
          if (w_hit1) begin
            w_bx  = POS_W'(P1_X + 1);
            w_dxr = 1'b1;
            w_dy2 = (w_a1 > sp_t'(PADDLE_HALF / 2));
          end else if (w_hit2) begin
            w_bx  = POS_W'(P2_X - 1);
            w_dxr = 1'b0;
            w_dy2 = (w_a2 > sp_t'(PADDLE_HALF / 2));
          end else begin
            w_bx  = w_nx[POS_W-1:0];
          end
          if (w_ny <= sp_t'(V_MIN)) begin
            w_by  = POS_W'(V_MIN);
            w_dyd = ~r_dyd;
          end else if (w_ny >= sp_t'(V_MAX)) begin
            w_by  = POS_W'(V_MAX);
            w_dyd = ~r_dyd;
          end else begin
            w_by  = w_ny[POS_W-1:0];
          end
        end
      end
      S_OVER: if (bus.start) begin
        w_s1 = '0; w_s2 = '0; w_win = 2'd0;
        w_bx = POS_W'(BALL_START_X);
        w_by = POS_W'(BALL_START_Y);
        w_dxr = 1'b1;
        w_cnt = '0;
        w_state = S_SERVE;
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_bx  <= POS_W'(BALL_START_X);
      r_by  <= POS_W'(BALL_START_Y);
      r_p1  <= POS_W'(PMID);
      r_p2  <= POS_W'(PMID);
      r_s1  <= '0;
      r_s2  <= '0;
      r_win <= 2'd0;
      r_cnt <= '0;
      r_pp  <= 1'b0;
      r_dxr <= 1'b1;
      r_dyd <= 1'b1;
      r_dy2 <= 1'b0;
    end else begin
      r_state <= w_state;
      r_bx  <= w_bx;
      r_by  <= w_by;
      r_p1  <= w_p1;
      r_p2  <= w_p2;
      r_s1  <= w_s1;
      r_s2  <= w_s2;
      r_win <= w_win;
      r_cnt <= w_cnt;
      r_pp  <= w_pp;
      r_dxr <= w_dxr;
      r_dyd <= w_dyd;
      r_dy2 <= w_dy2;
    end
  end

  assign bus.ballX      = r_bx;
  assign bus.ballY      = r_by;
  assign bus.paddle1Y   = r_p1;
  assign bus.paddle2Y   = r_p2;
  assign bus.score1     = r_s1;
  assign bus.score2     = r_s2;
  assign bus.gameState  = r_state;
  assign bus.winner     = r_win;
  assign bus.pointPulse = r_pp;
endmodule

// File: tb/tb_pong_game_engine.sv
// Randomized bench for pong_game_engine against an integer rules model of the game.
module tb_pong_game_engine;
  localparam int SD = 4;
  localparam int HMIN = 140, HMAX = 790, VMIN = 30, VMAX = 520;
  localparam int P1X = 200, P2X = 710, HALF = 20, STEP = 2, VX = 2;
  localparam int SX = 320, SY = 240, WIN = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pong_game_engine_if #(.POS_W(10), .SCORE_W(4)) bif();

  pong_game_engine #(.SERVE_DELAY(SD)) dut (.clk(clk), .reset(reset), .bus(bif));

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d", tag, act, exp);
  endtask

  // Rules model: plain integers, signed dx/dy.
  int m_st, m_bx, m_by, m_p1, m_p2, m_s1, m_s2, m_win, m_pp, m_cnt, m_dx, m_dy;

  task automatic m_reset();
    m_st = 0; m_bx = SX; m_by = SY; m_p1 = (VMIN + VMAX) / 2; m_p2 = m_p1;
    m_s1 = 0; m_s2 = 0; m_win = 0; m_pp = 0; m_cnt = 0; m_dx = VX; m_dy = 1;
  endtask

  function automatic int padl(input int y, input bit u, input bit d);
    int t;
    t = y + ((d && !u) ? STEP : 0) - ((u && !d) ? STEP : 0);
    if (t < VMIN + HALF) t = VMIN + HALF;
    if (t > VMAX - HALF) t = VMAX - HALF;
    return t;
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic model_step(input bit t, input bit s, input bit u1, input bit d1, input bit u2, input bit d2);
    int o1, o2, nx, ny, sgn;
    bit h1, h2, pt1, pt2;
    m_pp = 0;
    case (m_st)
      0: if (s) begin m_st = 1; m_cnt = 0; end
      1: if (t) begin
        m_p1 = padl(m_p1, u1, d1); m_p2 = padl(m_p2, u2, d2);
        if (m_cnt == SD - 1) m_st = 2; else m_cnt++;
      end
      2: if (t) begin
        o1 = m_p1; o2 = m_p2;
        m_p1 = padl(m_p1, u1, d1); m_p2 = padl(m_p2, u2, d2);
        nx = m_bx + m_dx;
        h1 = (m_dx < 0) && m_bx > P1X && nx <= P1X && iabs(m_by - o1) <= HALF;
        h2 = !h1 && (m_dx > 0) && m_bx < P2X && nx >= P2X && iabs(m_by - o2) <= HALF;
        pt2 = !h1 && !h2 && nx <= HMIN;
        pt1 = !h1 && !h2 && !pt2 && nx >= HMAX;
        if (pt1 || pt2) begin
          m_pp = 1; m_bx = SX; m_by = SY;
          sgn = (m_dy < 0) ? -1 : 1;
          m_dy = sgn; m_dx = pt1 ? VX : -VX; m_cnt = 0; m_st = 1;
          if (pt1) begin m_s1++; if (m_s1 == WIN) begin m_st = 3; m_win = 1; end end
          else     begin m_s2++; if (m_s2 == WIN) begin m_st = 3; m_win = 2; end end
        end else begin
          ny = m_by + m_dy;
          sgn = (m_dy < 0) ? -1 : 1;
          if (h1)      begin m_bx = P1X + 1; m_dx = VX;  m_dy = sgn * ((iabs(m_by - o1) > HALF / 2) ? 2 : 1); end
          else if (h2) begin m_bx = P2X - 1; m_dx = -VX; m_dy = sgn * ((iabs(m_by - o2) > HALF / 2) ? 2 : 1); end
          else m_bx = nx;
          if (ny <= VMIN)      begin m_by = VMIN; m_dy = -m_dy; end
          else if (ny >= VMAX) begin m_by = VMAX; m_dy = -m_dy; end
          else m_by = ny;
        end
      end
      3: if (s) begin
        m_s1 = 0; m_s2 = 0; m_win = 0; m_bx = SX; m_by = SY; m_dx = VX; m_cnt = 0; m_st = 1;
      end
      default: m_st = 0;
    endcase
  endtask

  task automatic check_all();
    chk("ballX", int'(bif.ballX), m_bx);
    chk("ballY", int'(bif.ballY), m_by);
    chk("paddle1Y", int'(bif.paddle1Y), m_p1);
    chk("paddle2Y", int'(bif.paddle2Y), m_p2);
    chk("score1", int'(bif.score1), m_s1);
    chk("score2", int'(bif.score2), m_s2);
    chk("gameState", int'(bif.gameState), m_st);
    chk("winner", int'(bif.winner), m_win);
    chk("pointPulse", int'(bif.pointPulse), m_pp);
  endtask

  // One clock: drive at negedge, model at posedge, compare at the next negedge.
  task automatic cyc(input bit t, input bit s, input bit u1, input bit d1, input bit u2, input bit d2);
    bif.tick = t; bif.start = s; bif.p1Up = u1; bif.p1Down = d1; bif.p2Up = u2; bif.p2Down = d2;
    @(posedge clk);
    model_step(t, s, u1, d1, u2, d2);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    bit over_seen, u1, d1, u2, d2, trk1, trk2;
    bif.tick = 0; bif.start = 0; bif.p1Up = 0; bif.p1Down = 0; bif.p2Up = 0; bif.p2Down = 0;
    reset = 1'b1;
    m_reset();
    repeat (2) @(negedge clk);
    check_all();
    chk("rst_state", int'(bif.gameState), 0);
    chk("rst_ballX", int'(bif.ballX), 320);
    chk("rst_pad1", int'(bif.paddle1Y), 275);
    reset = 1'b0;

    cyc(0, 1, 0, 0, 0, 0);
    chk("serve_entry", int'(bif.gameState), 1);
    repeat (3) cyc(1, 0, 0, 0, 0, 0);
    chk("serve_hold", int'(bif.gameState), 1);
    cyc(1, 0, 0, 0, 0, 0);
    chk("play_entry", int'(bif.gameState), 2);
    chk("play_bx0", int'(bif.ballX), 320);
    chk("play_by0", int'(bif.ballY), 240);
    cyc(1, 0, 0, 0, 0, 0);
    chk("first_bx", int'(bif.ballX), 322);
    chk("first_by", int'(bif.ballY), 241);

    repeat (200) cyc(1, 0, 1, 0, 0, 0);
    chk("p1_top_clamp", int'(bif.paddle1Y), 50);
    repeat (10) cyc(1, 0, 1, 1, 0, 0);
    chk("p1_both_hold", int'(bif.paddle1Y), 50);

    over_seen = 0;
    for (int seg = 0; seg < 16; seg++) begin
      trk1 = seg[0]; trk2 = seg[1];
      for (int i = 0; i < 2000; i++) begin
        u1 = 1'($urandom_range(0, 1)); d1 = 1'($urandom_range(0, 1));
        u2 = 1'($urandom_range(0, 1)); d2 = 1'($urandom_range(0, 1));
        if (trk1 && $urandom_range(0, 7) != 0) begin u1 = m_by < m_p1; d1 = m_by > m_p1; end
        if (trk2 && $urandom_range(0, 7) != 0) begin u2 = m_by < m_p2; d2 = m_by > m_p2; end
        cyc($urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0, u1, d1, u2, d2);
        if (m_st == 3) over_seen = 1;
      end
    end
    chk("over_reached", int'(over_seen), 1);

    for (int i = 0; i < 2000 && m_st != 2; i++) cyc(1, 1, 0, 0, 0, 0);
    chk("reach_play", int'(bif.gameState), 2);
    repeat (7) cyc(1, 0, 0, 1, 1, 0);
    #2 reset = 1'b1;
    #1 m_reset();
    check_all();
    chk("async_rst_state", int'(bif.gameState), 0);
    @(negedge clk);
    reset = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
